mtsp_axi4_rd_responder: RTL and testbench
=========================================

# mtsp_axi4_rd_responder

AXI4 read-channel completer that serves MTSP instruction, data and stack master ports from a local single-port synchronous SRAM. It accepts one read burst at a time and generates the read-data beats for it. It handles FIXED, INCR and WRAP bursts and returns error responses for illegal requests. It forms the memory-side end of the MTSP AXI master read path and replaces the bus model in stand-alone and FPGA builds.

## Interface
- C_ID_WIDTH, 1: ARID/RID width
- C_ADDR_WIDTH, 36: byte-address width
- C_DATA_WIDTH, 512: RDATA width; power of two, 32..1024
- C_BASE_ADDR, 0: byte address of SRAM word 0; aligned to SRAM size
- C_MEM_AW, 10: SRAM word-address width (depth 2^C_MEM_AW)
- MCLK  in  1  clock
- nRST  in  1  reset, active low, asynchronous assert; one clock, asynchronous active-low reset (fixed)
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST  in  C_ID_WIDTH/C_ADDR_WIDTH/8/3/2  read request
- ARVALID  in  1; ARREADY  out  1  request handshake
- ARLOCK/ARCACHE/ARPROT/ARQOS/ARREGION  in  1/4/3/4/4  ignored
- RID/RDATA/RRESP/RLAST  out  C_ID_WIDTH/C_DATA_WIDTH/2/1  read data
- RVALID  out  1; RREADY  in  1  data handshake
- MEM_EN  out  1  SRAM read strobe
- MEM_ADDR  out  C_MEM_AW  SRAM word address
- MEM_RDATA  in  C_DATA_WIDTH  SRAM data, valid the cycle after MEM_EN

## Operation
- Reset values: ARREADY=0, RVALID=0, RLAST=0, RRESP=0, RID=0, RDATA=0, MEM_EN=0, MEM_ADDR=0. State is IDLE. ARREADY rises on the first clock after nRST deasserts.
- FSM IDLE -> BURST on the AR handshake. In IDLE, ARREADY=1.
  - On the handshake, latch id, addr, len, size and burst, clear the issue and return counters, and evaluate the request-level error.
- FSM BURST -> IDLE on the RVALID&RREADY&RLAST handshake. ARREADY stays 0 throughout BURST.
- Request-level error gives SLVERR (2'b10) on all len+1 beats, with no SRAM access. It applies when any of these hold:
  - ARBURST=2'b11
  - ARSIZE > log2(C_DATA_WIDTH/8)
  - WRAP with len not in {1,3,7,15}
  - WRAP with addr unaligned to 2^size
- Beat address: beat 0 is ARADDR.
  - FIXED: every beat uses ARADDR.
  - INCR: aligned(addr) + n·2^size. Crossing the 4 KB boundary is not checked.
  - WRAP: wrap boundary = (len+1)·2^size. Lower bits wrap modulo that size.
- Per-beat decode: a beat address outside [C_BASE_ADDR, C_BASE_ADDR + 2^C_MEM_AW·C_DATA_WIDTH/8) gets DECERR (2'b11), RDATA=0 and no MEM_EN. Other beats in the same burst are unaffected.
- MEM_ADDR = (beat_addr − C_BASE_ADDR) >> log2(C_DATA_WIDTH/8). Full RDATA word returned; narrow beats are not lane-shifted.
- Return buffer: 2-entry FIFO of {data, resp, last}. Error beats enter the FIFO in the same slot pattern as SRAM beats, so ordering is preserved.
- Issue rule: issue beat when fifo_count + inflight − pop < 2 and issued ≤ len. Each cycle holds one issue at most.
- RID = latched id on every beat. RLAST marks beat len only.

## Timing
- AR handshake in cycle T. First MEM_EN in T+1. Captured into the FIFO at the end of T+2. First RVALID in T+3.
- With RREADY held high: one beat per cycle. The burst ends T+3+len. Next ARREADY is in cycle T+4+len.
- RVALID, RDATA, RRESP, RLAST and RID are stable while RVALID && !RREADY (AXI rule). RREADY low stalls issue within 1 cycle. SRAM data is never dropped.
- Pop and push may occur in the same cycle; the count is unchanged.
- Async reset mid-burst: the FIFO, counters and FSM clear immediately and outputs go to their reset values. No partial burst resumes.

## Structure
- Package mtsp_axi_pkg holds:
  - burst enum FIXED/INCR/WRAP
  - RRESP constants OKAY/SLVERR/DECERR
  - FSM state enum
  - beat-address function next_addr(addr, size, len, burst)
- Sub-module mtsp_axi_rd_fifo: 2-deep registered FIFO with count output. Everything else lives in the top.

## Test plan
- INCR burst: ARADDR=C_BASE_ADDR+0x80, ARLEN=3, ARSIZE=6, RREADY=1 -> MEM_ADDR 2,3,4,5, four OKAY beats, RLAST on the 4th, first RVALID exactly 3 cycles after the handshake.
- WRAP burst: ARADDR=base+0xC0, ARLEN=3, size 6 -> MEM_ADDR 3,0,1,2. Also ARLEN=2 WRAP -> 3 SLVERR beats, MEM_EN never asserted.
- Backpressure: RREADY toggles 1,0,0,1 repeating on ARLEN=15 INCR -> 16 beats in order, data matches SRAM, no loss or duplication, outputs stable while stalled.
- Out-of-range crossing: INCR starting 2 words below the SRAM top, ARLEN=3 -> OKAY, OKAY, DECERR, DECERR; DECERR beats carry RDATA=0.
- FIXED burst: ARLEN=2 with ARID=1 -> three beats of the same word, RID=1 on all; ARREADY=0 until the last beat's handshake.
- Reset: nRST low at the 2nd beat of an ARLEN=7 burst -> RVALID=0 the same cycle. After release, a new AR is accepted and starts at its beat 0.

Source files
------------

// File: rtl/mtsp_axi_pkg.sv
// rtl/mtsp_axi_pkg.sv - burst/response/state types and beat-address helper for the AXI4 read responder
package mtsp_axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_e;

  // Address of the beat after addr; callers zero-extend to 64 bits and truncate the result.
  // INCR aligns first so an unaligned start only affects beat 0.
  function automatic logic [63:0] next_addr(input logic [63:0] addr, input logic [2:0] size,
                                            input logic [7:0] len, input burst_e burst);
    logic [63:0] step;
    logic [63:0] wmask;
    logic [63:0] res;
    step  = 64'd1 << size;
    wmask = ((64'(len) + 64'd1) << size) - 64'd1;
    case (burst)
      BURST_FIXED: res = addr;
      BURST_WRAP:  res = (addr & ~wmask) | ((addr + step) & wmask);
      default:     res = (addr & ~(step - 64'd1)) + step;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mtsp_axi_rd_fifo.sv
// rtl/mtsp_axi_rd_fifo.sv - 2-deep registered return FIFO with occupancy count
module mtsp_axi_rd_fifo #(
  parameter int C_WIDTH = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_push,
  input  logic [C_WIDTH-1:0] i_data,
  input  logic               i_pop,
  output logic [C_WIDTH-1:0] o_data,
  output logic               o_valid,
  output logic [1:0]         o_count
);

  logic [C_WIDTH-1:0] r_mem [2];
  logic               r_wr_ptr;
  logic               r_rd_ptr;
  logic [1:0]         r_count;
  logic               w_push;
  logic               w_pop;

  assign w_pop  = i_pop && (r_count != 2'd0);
  assign w_push = i_push && ((r_count != 2'd2) || w_pop);

  // Storage, pointers and count; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_valid = (r_count != 2'd0);
  assign o_count = r_count;

endmodule

// File: rtl/mtsp_axi4_rd_responder.sv
// rtl/mtsp_axi4_rd_responder.sv - AXI4 read completer serving bursts from a local synchronous SRAM
module mtsp_axi4_rd_responder
  import mtsp_axi_pkg::*;
#(
  parameter int                      C_ID_WIDTH   = 1,
  parameter int                      C_ADDR_WIDTH = 36,
  parameter int                      C_DATA_WIDTH = 512,
  parameter logic [C_ADDR_WIDTH-1:0] C_BASE_ADDR  = '0,
  parameter int                      C_MEM_AW     = 10
) (
  input  logic                    MCLK,
  input  logic                    nRST,
  input  logic [C_ID_WIDTH-1:0]   ARID,
  input  logic [C_ADDR_WIDTH-1:0] ARADDR,
  input  logic [7:0]              ARLEN,
  input  logic [2:0]              ARSIZE,
  input  logic [1:0]              ARBURST,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  input  logic                    ARLOCK,
  input  logic [3:0]              ARCACHE,
  input  logic [2:0]              ARPROT,
  input  logic [3:0]              ARQOS,
  input  logic [3:0]              ARREGION,
  output logic [C_ID_WIDTH-1:0]   RID,
  output logic [C_DATA_WIDTH-1:0] RDATA,
  output logic [1:0]              RRESP,
  output logic                    RLAST,
  output logic                    RVALID,
  input  logic                    RREADY,
  output logic                    MEM_EN,
  output logic [C_MEM_AW-1:0]     MEM_ADDR,
  input  logic [C_DATA_WIDTH-1:0] MEM_RDATA
);

  localparam int LP_LB = $clog2(C_DATA_WIDTH / 8);
  localparam int LP_HI = LP_LB + C_MEM_AW;
  localparam int LP_FW = C_DATA_WIDTH + 3;

  state_e                  r_state;
  logic                    r_arready;
  logic [C_ID_WIDTH-1:0]   r_id;
  logic [C_ADDR_WIDTH-1:0] r_addr;
  logic [7:0]              r_len;
  logic [2:0]              r_size;
  burst_e                  r_burst;
  logic                    r_slverr;
  logic [8:0]              r_issued;
  logic                    r_inflight;
  logic [1:0]              r_infl_resp;
  logic                    r_infl_last;

  logic                    w_ar_hs;
  logic                    w_pop;
  logic                    w_fifo_valid;
  logic [LP_FW-1:0]        w_fifo_dout;
  logic [LP_FW-1:0]        w_fifo_din;
  logic [1:0]              w_fifo_count;
  logic [2:0]              w_occ;
  logic                    w_issue;
  logic                    w_last_beat;
  logic                    w_in_range;
  logic [1:0]              w_beat_resp;
  logic [63:0]             w_next_addr;
  logic                    w_wrap_len_ok;
  logic [63:0]             w_size_mask;
  logic                    w_wrap_misalign;
  logic                    w_req_err;
  logic                    w_unused;

  assign w_ar_hs = ARVALID && r_arready;
  assign w_pop   = w_fifo_valid && RREADY;

  // Request-level errors are decided once at acceptance and applied to every beat.
  assign w_wrap_len_ok   = (ARLEN == 8'd1) || (ARLEN == 8'd3) || (ARLEN == 8'd7) || (ARLEN == 8'd15);
  assign w_size_mask     = (64'd1 << ARSIZE) - 64'd1;
  assign w_wrap_misalign = (64'(ARADDR) & w_size_mask) != 64'd0;
  assign w_req_err       = (ARBURST == 2'b11) || (int'(ARSIZE) > LP_LB) ||
                           ((ARBURST == BURST_WRAP) && (!w_wrap_len_ok || w_wrap_misalign));

  // Base is aligned to the SRAM size, so range decode and word index come straight from address bits.
  assign w_in_range  = (r_addr >> LP_HI) == (C_BASE_ADDR >> LP_HI);
  assign w_beat_resp = r_slverr ? RESP_SLVERR : (w_in_range ? RESP_OKAY : RESP_DECERR);
  assign w_next_addr = next_addr(64'(r_addr), r_size, r_len, r_burst);
  assign w_last_beat = (r_issued == {1'b0, r_len});

  // A beat may issue only if its result is guaranteed a FIFO slot, counting the one leaving this cycle.
  assign w_occ   = {1'b0, w_fifo_count} + {2'b00, r_inflight};
  assign w_issue = (r_state == S_BURST) && (r_issued <= {1'b0, r_len}) &&
                   (w_occ < (3'd2 + {2'b00, w_pop}));

  assign MEM_EN   = w_issue && (w_beat_resp == RESP_OKAY);
  assign MEM_ADDR = r_addr[LP_LB +: C_MEM_AW];

  // Burst FSM: request latching, beat address stepping and the one-cycle SRAM return pipeline.
  always_ff @(posedge MCLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= S_IDLE;
      r_arready   <= 1'b0;
      r_id        <= '0;
      r_addr      <= '0;
      r_len       <= 8'd0;
      r_size      <= 3'd0;
      r_burst     <= BURST_FIXED;
      r_slverr    <= 1'b0;
      r_issued    <= 9'd0;
      r_inflight  <= 1'b0;
      r_infl_resp <= RESP_OKAY;
      r_infl_last <= 1'b0;
    end else begin
      r_inflight  <= w_issue;
      r_infl_resp <= w_beat_resp;
      r_infl_last <= w_last_beat;
      if (w_issue) begin
        r_addr   <= C_ADDR_WIDTH'(w_next_addr);
        r_issued <= r_issued + 9'd1;
      end
      case (r_state)
        S_IDLE: begin
          r_arready <= 1'b1;
          if (w_ar_hs) begin
            r_state   <= S_BURST;
            r_arready <= 1'b0;
            r_id      <= ARID;
            r_addr    <= ARADDR;
            r_len     <= ARLEN;
            r_size    <= ARSIZE;
            r_burst   <= burst_e'(ARBURST);
            r_slverr  <= w_req_err;
            r_issued  <= 9'd0;
          end
        end
        S_BURST: begin
          if (w_pop && w_fifo_dout[0]) begin
            r_state   <= S_IDLE;
            r_arready <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Error beats carry zero data but still flow through the FIFO in SRAM-beat order.
  assign w_fifo_din = {((r_infl_resp == RESP_OKAY) ? MEM_RDATA : {C_DATA_WIDTH{1'b0}}),
                       r_infl_resp, r_infl_last};

  mtsp_axi_rd_fifo #(
    .C_WIDTH (LP_FW)
  ) u_fifo (
    .i_clk   (MCLK),
    .i_rst_n (nRST),
    .i_push  (r_inflight),
    .i_data  (w_fifo_din),
    .i_pop   (w_pop),
    .o_data  (w_fifo_dout),
    .o_valid (w_fifo_valid),
    .o_count (w_fifo_count)
  );

  assign ARREADY = r_arready;
  assign RVALID  = w_fifo_valid;
  assign RDATA   = w_fifo_dout[LP_FW-1:3];
  assign RRESP   = w_fifo_dout[2:1];
  assign RLAST   = w_fifo_dout[0];
  assign RID     = r_id;

  assign w_unused = ^{ARLOCK, ARCACHE, ARPROT, ARQOS, ARREGION, w_next_addr};

endmodule

// File: tb/tb_mtsp_axi4_rd_responder.sv
// tb/tb_mtsp_axi4_rd_responder.sv - scoreboard bench for the AXI4 read responder
module tb_mtsp_axi4_rd_responder;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef struct {
    logic         id;
    logic [511:0] data;
    logic [1:0]   resp;
    logic         last;
    bit           chk_data;
  } exp_t;

  logic         MCLK;
  logic         nRST;
  logic [0:0]   ARID;
  logic [35:0]  ARADDR;
  logic [7:0]   ARLEN;
  logic [2:0]   ARSIZE;
  logic [1:0]   ARBURST;
  logic         ARVALID;
  logic         ARREADY;
  logic         ARLOCK = 1'b0;
  logic [3:0]   ARCACHE = 4'd0;
  logic [2:0]   ARPROT = 3'd0;
  logic [3:0]   ARQOS = 4'd0;
  logic [3:0]   ARREGION = 4'd0;
  logic [0:0]   RID;
  logic [511:0] RDATA;
  logic [1:0]   RRESP;
  logic         RLAST;
  logic         RVALID;
  logic         RREADY;
  logic         MEM_EN;
  logic [9:0]   MEM_ADDR;
  logic [511:0] MEM_RDATA = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t_hs = 0;
  int beats_done = 0;
  bit busy = 0;
  bit first_pending = 0;
  bit arready_due = 0;
  bit prev_stall = 0;
  bit bp_en = 0;
  int bp_idx = 0;
  logic [3:0] bp_pat = 4'b1001;
  logic [511:0] p_data;
  logic [1:0] p_resp;
  logic p_last;
  logic [0:0] p_id;
  exp_t exp_q[$];
  int mem_q[$];
  exp_t mon_e;

  mtsp_axi4_rd_responder dut (
    .MCLK(MCLK), .nRST(nRST),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT), .ARQOS(ARQOS), .ARREGION(ARREGION),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .MEM_EN(MEM_EN), .MEM_ADDR(MEM_ADDR), .MEM_RDATA(MEM_RDATA)
  );

  initial begin
    MCLK = 0;
    forever #5 MCLK = ~MCLK;
  end

  always @(posedge MCLK) cyc <= cyc + 1;

  function automatic logic [511:0] mem_word(input logic [9:0] a);
    return {16{22'h15a5a5, a}};
  endfunction

  // SRAM model: data appears the cycle after the read strobe.
  always @(posedge MCLK) if (MEM_EN) MEM_RDATA <= mem_word(MEM_ADDR);

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic exp_beat(input logic id, input int word, input logic [1:0] resp, input logic last,
                          input bit chk_data);
    exp_t e;
    e.id = id;
    e.data = (resp == OKAY) ? mem_word(word[9:0]) : '0;
    e.resp = resp;
    e.last = last;
    e.chk_data = chk_data;
    exp_q.push_back(e);
    if (resp == OKAY) mem_q.push_back(word);
  endtask

  task automatic flush();
    exp_q.delete();
    mem_q.delete();
    busy = 0;
    first_pending = 0;
    prev_stall = 0;
    arready_due = 0;
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_arready"}, ARREADY, 0);
    chk({nm, "_rvalid"}, RVALID, 0);
    chk({nm, "_rlast"}, RLAST, 0);
    chk({nm, "_rresp"}, RRESP, 0);
    chk({nm, "_rid"}, RID, 0);
    chk({nm, "_rdata"}, RDATA, 0);
    chk({nm, "_mem_en"}, MEM_EN, 0);
    chk({nm, "_mem_addr"}, MEM_ADDR, 0);
  endtask

  task automatic release_reset();
    @(posedge MCLK); #1;
    nRST = 1;
    #1;
    chk("arready_before_clk", ARREADY, 0);
    @(posedge MCLK); #1;
    chk("arready_after_clk", ARREADY, 1);
  endtask

  task automatic send_ar(input logic id, input logic [35:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    bit ok;
    ok = 0;
    @(posedge MCLK); #1;
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge MCLK);
      if (ARREADY) begin
        ok = 1;
        t_hs = cyc;
        break;
      end
    end
    chk("ar_accept", ok, 1);
    @(posedge MCLK); #1;
    ARVALID = 0;
    if (ok) begin
      busy = 1;
      first_pending = 1;
    end
  endtask

  task automatic wait_idle(input string nm);
    bit done;
    done = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge MCLK); #1;
      if (!busy) begin
        done = 1;
        break;
      end
    end
    chk({nm, "_done"}, done, 1);
    chk({nm, "_beats_left"}, exp_q.size(), 0);
    chk({nm, "_mem_left"}, mem_q.size(), 0);
    if (!done) flush();
    repeat (2) @(posedge MCLK);
  endtask

  // RREADY driver: held high, or the 1,0,0,1 pattern while backpressure is enabled.
  initial begin
    RREADY = 1;
    forever begin
      @(posedge MCLK); #1;
      if (bp_en) begin
        RREADY = bp_pat[bp_idx];
        bp_idx = (bp_idx + 1) % 4;
      end else begin
        RREADY = 1;
      end
    end
  end

  // Monitor: samples mid-cycle, checks SRAM strobes, handshakes and stall stability.
  initial forever begin
    @(negedge MCLK);
    if (nRST) begin
      if (MEM_EN) begin
        if (mem_q.size() == 0) chk("mem_en_unexpected", MEM_EN, 0);
        else chk("mem_addr", MEM_ADDR, mem_q.pop_front());
      end
      if (arready_due) begin
        chk("arready_after_last", ARREADY, 1);
        arready_due = 0;
      end else if (busy) begin
        chk("arready_busy", ARREADY, 0);
      end
      if (RVALID) begin
        if (first_pending) begin
          chk("first_rvalid_latency", cyc - t_hs, 3);
          first_pending = 0;
        end
        if (prev_stall) begin
          chk("stall_rdata", RDATA, p_data);
          chk("stall_rresp", RRESP, p_resp);
          chk("stall_rlast", RLAST, p_last);
          chk("stall_rid", RID, p_id);
        end
        if (RREADY) begin
          if (exp_q.size() == 0) begin
            chk("rvalid_unexpected", RVALID, 0);
          end else begin
            mon_e = exp_q.pop_front();
            chk("rid", RID, mon_e.id);
            chk("rresp", RRESP, mon_e.resp);
            chk("rlast", RLAST, mon_e.last);
            if (mon_e.chk_data) chk("rdata", RDATA, mon_e.data);
            beats_done++;
            if (mon_e.last) begin
              busy = 0;
              arready_due = 1;
            end
          end
          prev_stall = 0;
        end else begin
          prev_stall = 1;
          p_data = RDATA; p_resp = RRESP; p_last = RLAST; p_id = RID;
        end
      end else begin
        if (prev_stall) chk("rvalid_dropped", RVALID, 1);
        prev_stall = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    nRST = 1; ARVALID = 0; ARID = 0; ARADDR = 0; ARLEN = 0; ARSIZE = 0; ARBURST = 0;
    #1 nRST = 0;
    repeat (2) @(posedge MCLK);
    #1;
    check_reset_vals("por");
    release_reset();

    // INCR, aligned
    exp_beat(0, 2, OKAY, 0, 1); exp_beat(0, 3, OKAY, 0, 1);
    exp_beat(0, 4, OKAY, 0, 1); exp_beat(0, 5, OKAY, 1, 1);
    send_ar(0, 36'h80, 8'd3, 3'd6, 2'b01);
    wait_idle("incr");

    // WRAP from the top of a 256-byte window
    exp_beat(0, 3, OKAY, 0, 1); exp_beat(0, 0, OKAY, 0, 1);
    exp_beat(0, 1, OKAY, 0, 1); exp_beat(0, 2, OKAY, 1, 1);
    send_ar(0, 36'hC0, 8'd3, 3'd6, 2'b10);
    wait_idle("wrap");

    // WRAP with illegal length
    exp_beat(0, 0, SLVERR, 0, 0); exp_beat(0, 0, SLVERR, 0, 0); exp_beat(0, 0, SLVERR, 1, 0);
    send_ar(0, 36'hC0, 8'd2, 3'd6, 2'b10);
    wait_idle("wrap_len2");

    // Backpressure over a 16-beat INCR
    for (int i = 0; i < 16; i++) exp_beat(0, 16 + i, OKAY, (i == 15), 1);
    bp_idx = 0;
    bp_en = 1;
    send_ar(0, 36'h400, 8'd15, 3'd6, 2'b01);
    wait_idle("backpressure");
    bp_en = 0;

    // Crossing the SRAM top
    exp_beat(0, 1022, OKAY, 0, 1); exp_beat(0, 1023, OKAY, 0, 1);
    exp_beat(0, 0, DECERR, 0, 1); exp_beat(0, 0, DECERR, 1, 1);
    send_ar(0, 36'hFF80, 8'd3, 3'd6, 2'b01);
    wait_idle("decerr");

    // FIXED with ID 1
    exp_beat(1, 8, OKAY, 0, 1); exp_beat(1, 8, OKAY, 0, 1); exp_beat(1, 8, OKAY, 1, 1);
    send_ar(1, 36'h200, 8'd2, 3'd6, 2'b00);
    wait_idle("fixed");

    // Oversized beat
    exp_beat(0, 0, SLVERR, 1, 0);
    send_ar(0, 36'h0, 8'd0, 3'd7, 2'b01);
    wait_idle("size_err");

    // Unaligned INCR start: only beat 0 is unaligned
    exp_beat(0, 2, OKAY, 0, 1); exp_beat(0, 3, OKAY, 1, 1);
    send_ar(0, 36'h90, 8'd1, 3'd6, 2'b01);
    wait_idle("unaligned");

    // Reset in the middle of an 8-beat burst
    for (int i = 0; i < 8; i++) exp_beat(0, 32 + i, OKAY, (i == 7), 1);
    beats_done = 0;
    send_ar(0, 36'h800, 8'd7, 3'd6, 2'b01);
    begin
      bit seen;
      seen = 0;
      for (int i = 0; i < 50; i++) begin
        @(posedge MCLK); #1;
        if (beats_done >= 1) begin
          seen = 1;
          break;
        end
      end
      chk("rst_first_beat_seen", seen, 1);
    end
    chk("rst_rvalid_before", RVALID, 1);
    nRST = 0;
    flush();
    #1;
    check_reset_vals("rst_mid");
    repeat (2) @(posedge MCLK);
    release_reset();
    exp_beat(0, 4, OKAY, 0, 1); exp_beat(0, 5, OKAY, 1, 1);
    send_ar(0, 36'h100, 8'd1, 3'd6, 2'b01);
    wait_idle("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
